mux_nbuf: RTL and testbench
===========================

Name: mux_nbuf

Overview:
- Parametrised successor to the double-buffered register mux: a register bank of num_reg words with 2 or 3 buffer copies.
- A writer fills the back buffer and marks it complete with write_done. The reader samples a stable front buffer and adopts the newest completed buffer on read_latch.
- num_buf=3 gives triple buffering: the writer never stalls or corrupts the pending frame.
- The block sits between the frame/config producer and the display-timing consumer.

Parameters:
- width, 16: bits per register word.
- num_reg, 3: words per buffer. Address width is clog2(num_reg), minimum 1.
- num_buf, 2: buffer count. Legal values are 2 or 3; any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- write_addr  in  addr_width  word index for a write
- write_data  in  width  write payload
- write_enable  in  1  write write_data to the write buffer this cycle
- write_done  in  1  write buffer complete; single-cycle strobe
- read_addr  in  addr_width  word index for a read
- read_data  out  width  registered read result
- read_latch  in  1  reader frame boundary; adopt the pending buffer if one exists
- pending  out  1  a completed buffer is waiting for read_latch
- swapped  out  1  one-cycle pulse the cycle after the read buffer changes
- drop_count  out  8  completed frames discarded before being read (optional feature)

Behaviour:
- State: rd_idx, wr_idx, pd_idx (buffer indices), pend_valid.
- Reset: rd_idx=0, wr_idx=1, pd_idx=2 (num_buf=3) or 1 (num_buf=2), pend_valid=0. All storage words=0, read_data=0, swapped=0, drop_count=0.
- pending = pend_valid (registered state).
- Write: if write_enable and write_addr<num_reg, buf[wr_idx][write_addr] <= write_data. wr_idx is the pre-edge value, so a write in the same cycle as write_done lands in the completing buffer. Out-of-range writes are ignored.
- Read: read_data <= (read_addr<num_reg) ? buf[rd_idx][read_addr] : 0. Latency is 1 cycle, using the pre-edge rd_idx. The new buffer is visible for read_addr presented in the cycle after the swap edge.
- Writer and reader always see different buffers. A write never reaches buf[rd_idx].
- latch_eff = read_latch && pend_valid (pre-edge). read_latch with pend_valid=0 does nothing.
- num_buf=2 (matches previous generation):
  - write_done: pend_valid<=1. The writer keeps wr_idx; continued writes modify the pending buffer.
  - latch_eff: rd_idx<=wr_idx, wr_idx<=rd_idx, pend_valid<=0.
  - write_done and latch_eff together: swap occurs and pend_valid stays 1.
  - write_done while pend_valid=1 without read_latch: drop_count++.
- num_buf=3:
  - write_done only, pend_valid=0: pd_idx<=wr_idx, wr_idx<=pd_idx, pend_valid<=1.
  - write_done only, pend_valid=1: pd_idx<=wr_idx, wr_idx<=pd_idx (old frame dropped, buffer reused), drop_count++.
  - latch_eff only: rd_idx<=pd_idx, pd_idx<=rd_idx, pend_valid<=0.
  - write_done and latch_eff together: rd_idx<=pd_idx, pd_idx<=wr_idx, wr_idx<=old rd_idx, pend_valid stays 1. No drop.
  - write_done and read_latch with pend_valid=0: write_done-only rule applies.
- The three indices always form a permutation of {0,1,2}.
- swapped <= latch_eff.
- drop_count saturates at 255.
- Reset asserted mid-frame: all state and storage return to reset values immediately. A partial frame is lost.

Optional Feature:
- Macro MUXBUF_DROP_COUNT_EN.
- Defined: drop_count is implemented as above.
- Undefined: drop_count is tied to 0 and the counter logic is absent. All other behaviour is unchanged.

Test Plan:
- num_buf=2, reset, read addr 0..2 -> read_data 0,0,0 one cycle after each address; pending=0.
- num_buf=2: write 0x1111/0x2222/0x3333 to words 0..2, write_done, read_latch next cycle -> swapped=1 for one cycle; reads return 0x1111,0x2222,0x3333; pending=0.
- num_buf=2: write_done and read_latch in the same cycle with pend_valid=1 -> swap occurs and pending stays 1. A second read_latch swaps back.
- num_buf=3: frame A (word0=0xAAAA) write_done, frame B (word0=0xBBBB) write_done, then read_latch -> word0 reads 0xBBBB; drop_count=1 with MUXBUF_DROP_COUNT_EN.
- num_buf=3: write 0xCCCC while read_latch toggles every 4 cycles with no write_done -> read_data never changes and never shows 0xCCCC; swapped stays 0.
- Assert rst mid-frame after a partial write of 0x5555 -> read_data=0 at once. After release, reads return 0 and pending=0.

Source files
------------

// File: rtl/mux_nbuf.sv
// mux_nbuf: register bank of num_reg words held in num_buf (2 or 3) buffer
// copies. The writer fills its own buffer and marks it complete with
// write_done; the reader keeps a stable front buffer and adopts the newest
// completed buffer on read_latch.
// Optional feature macro: MUXBUF_DROP_COUNT_EN (enables drop_count).
module mux_nbuf #(
  parameter int width   = 16,
  parameter int num_reg = 3,
  parameter int num_buf = 2,
  localparam int addr_width = (num_reg > 1) ? $clog2(num_reg) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] write_addr,
  input  logic [width-1:0]      write_data,
  input  logic                  write_enable,
  input  logic                  write_done,
  input  logic [addr_width-1:0] read_addr,
  output logic [width-1:0]      read_data,
  input  logic                  read_latch,
  output logic                  pending,
  output logic                  swapped,
  output logic [7:0]            drop_count
);

  generate
    if (num_buf != 2 && num_buf != 3) begin : g_bad_num_buf
      $error("mux_nbuf: num_buf must be 2 or 3");
    end
  endgenerate

  localparam logic [1:0] PD_RST = (num_buf == 3) ? 2'd2 : 2'd1;

  logic [width-1:0] mem_q [num_buf][num_reg];
  logic [width-1:0] read_data_q;
  logic [width-1:0] rd_word;
  logic [1:0]       rd_idx_q, rd_idx_d;
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       pd_idx_q, pd_idx_d;
  logic             pend_q, pend_d;
  logic             swapped_q;
  logic             latch_eff;

  assign latch_eff = read_latch && pend_q;

  // Storage: writes land in the pre-edge writer buffer; out-of-range addresses match no word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < num_buf; b++)
        for (int unsigned w = 0; w < num_reg; w++)
          mem_q[b][w] <= '0;
    end else if (write_enable) begin
      for (int unsigned b = 0; b < num_buf; b++)
        for (int unsigned w = 0; w < num_reg; w++)
          if (wr_idx_q == b[1:0] && write_addr == w[addr_width-1:0])
            mem_q[b][w] <= write_data;
    end
  end

  // Read mux over the front buffer; unmatched addresses yield zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < num_buf; b++)
      for (int unsigned w = 0; w < num_reg; w++)
        if (rd_idx_q == b[1:0] && read_addr == w[addr_width-1:0])
          rd_word = mem_q[b][w];
  end

  // Buffer index rotation on write_done / effective read_latch.
  always_comb begin
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    pd_idx_d = pd_idx_q;
    pend_d   = pend_q;
    if (num_buf == 2) begin
      // Two buffers: the completed buffer stays with the writer until the reader takes it.
      if (latch_eff) begin
        rd_idx_d = wr_idx_q;
        wr_idx_d = rd_idx_q;
        pend_d   = write_done;
      end else if (write_done) begin
        pend_d = 1'b1;
      end
    end else begin
      if (write_done && latch_eff) begin
        rd_idx_d = pd_idx_q;
        pd_idx_d = wr_idx_q;
        wr_idx_d = rd_idx_q;
        pend_d   = 1'b1;
      end else if (write_done) begin
        pd_idx_d = wr_idx_q;
        wr_idx_d = pd_idx_q;
        pend_d   = 1'b1;
      end else if (latch_eff) begin
        rd_idx_d = pd_idx_q;
        pd_idx_d = rd_idx_q;
        pend_d   = 1'b0;
      end
    end
  end

  // Control state, registered read result and swap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_q    <= 2'd0;
      wr_idx_q    <= 2'd1;
      pd_idx_q    <= PD_RST;
      pend_q      <= 1'b0;
      swapped_q   <= 1'b0;
      read_data_q <= '0;
    end else begin
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      pd_idx_q    <= pd_idx_d;
      pend_q      <= pend_d;
      swapped_q   <= latch_eff;
      read_data_q <= rd_word;
    end
  end

`ifdef MUXBUF_DROP_COUNT_EN
  logic [7:0] drop_q;
  logic       drop_inc;

  // A completed frame is dropped when another completes before the reader took it.
  assign drop_inc = write_done && pend_q && !latch_eff;

  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_q <= '0;
    else if (drop_inc && drop_q != '1)
      drop_q <= drop_q + 8'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  assign read_data = read_data_q;
  assign pending   = pend_q;
  assign swapped   = swapped_q;

endmodule

// File: tb/tb_mux_nbuf.sv
// Directed bench for mux_nbuf: one double-buffered (a_*) and one
// triple-buffered (b_*) instance sharing clock and reset.
module tb_mux_nbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  a_waddr = '0, a_raddr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_we = 1'b0, a_wd = 1'b0, a_rl = 1'b0;
  logic [15:0] a_rdata;
  logic        a_pend, a_swp;
  logic [7:0]  a_drop;

  logic [1:0]  b_waddr = '0, b_raddr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_we = 1'b0, b_wd = 1'b0, b_rl = 1'b0;
  logic [15:0] b_rdata;
  logic        b_pend, b_swp;
  logic [7:0]  b_drop;

  int checks = 0;
  int errors = 0;

`ifdef MUXBUF_DROP_COUNT_EN
  localparam logic [15:0] DROP1 = 16'd1;
`else
  localparam logic [15:0] DROP1 = 16'd0;
`endif

  mux_nbuf #(.width(16), .num_reg(3), .num_buf(2)) dut_a (
    .clk(clk), .rst(rst),
    .write_addr(a_waddr), .write_data(a_wdata), .write_enable(a_we),
    .write_done(a_wd), .read_addr(a_raddr), .read_data(a_rdata),
    .read_latch(a_rl), .pending(a_pend), .swapped(a_swp), .drop_count(a_drop)
  );

  mux_nbuf #(.width(16), .num_reg(3), .num_buf(3)) dut_b (
    .clk(clk), .rst(rst),
    .write_addr(b_waddr), .write_data(b_wdata), .write_enable(b_we),
    .write_done(b_wd), .read_addr(b_raddr), .read_data(b_rdata),
    .read_latch(b_rl), .pending(b_pend), .swapped(b_swp), .drop_count(b_drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_a [3];
    logic [15:0] last_b;
    exp_a[0] = 16'h1111; exp_a[1] = 16'h2222; exp_a[2] = 16'h3333;

    // Reset state
    #2;
    check("rst_a_rdata", a_rdata, 16'h0);
    check("rst_a_pend",  {15'd0, a_pend}, 16'h0);
    check("rst_b_swp",   {15'd0, b_swp}, 16'h0);
    check("rst_b_drop",  {8'd0, b_drop}, 16'h0);
    tick(); tick();
    rst = 1'b0;

    // nb2: empty bank reads zero
    for (int i = 0; i < 3; i++) begin
      a_raddr = 2'(i);
      tick();
      check("a_empty_read", a_rdata, 16'h0);
    end
    check("a_empty_pend", {15'd0, a_pend}, 16'h0);

    // nb2: fill back buffer, complete, latch
    a_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_waddr = 2'(i); a_wdata = exp_a[i];
      tick();
    end
    a_we = 1'b0;
    a_wd = 1'b1; a_raddr = 2'd0;
    tick();
    a_wd = 1'b0;
    check("a_pend_after_done", {15'd0, a_pend}, 16'h1);
    check("a_front_untouched", a_rdata, 16'h0);
    a_rl = 1'b1;
    tick();
    a_rl = 1'b0;
    check("a_swapped_pulse", {15'd0, a_swp}, 16'h1);
    check("a_pend_cleared", {15'd0, a_pend}, 16'h0);
    tick();
    check("a_swapped_end", {15'd0, a_swp}, 16'h0);
    for (int i = 0; i < 3; i++) begin
      a_raddr = 2'(i);
      tick();
      check("a_frame_read", a_rdata, exp_a[i]);
    end
    a_raddr = 2'd3;
    a_we = 1'b1; a_waddr = 2'd3; a_wdata = 16'hDEAD;
    tick();
    a_we = 1'b0;
    check("a_oor_read", a_rdata, 16'h0);

    // nb2: write_done + read_latch together while pending
    a_we = 1'b1; a_waddr = 2'd0; a_wdata = 16'h4444;
    tick();
    a_we = 1'b0;
    a_wd = 1'b1;
    tick();
    a_wd = 1'b1; a_rl = 1'b1;
    tick();
    a_wd = 1'b0; a_rl = 1'b0;
    check("a_sim_swapped", {15'd0, a_swp}, 16'h1);
    check("a_sim_pend", {15'd0, a_pend}, 16'h1);
    a_raddr = 2'd0;
    tick();
    check("a_sim_read", a_rdata, 16'h4444);
    check("a_sim_nodrop", {8'd0, a_drop}, 16'h0);
    a_rl = 1'b1;
    tick();
    a_rl = 1'b0;
    tick();
    check("a_swapback_read", a_rdata, 16'h1111);
    check("a_swapback_pend", {15'd0, a_pend}, 16'h0);
    a_wd = 1'b1;
    tick(); tick();
    a_wd = 1'b0;
    check("a_drop", {8'd0, a_drop}, DROP1);

    // nb3: frame A then frame B, then latch
    b_we = 1'b1; b_waddr = 2'd0; b_wdata = 16'hAAAA;
    tick();
    b_we = 1'b0; b_wd = 1'b1;
    tick();
    b_wd = 1'b0;
    b_we = 1'b1; b_wdata = 16'hBBBB;
    tick();
    b_we = 1'b0; b_wd = 1'b1;
    tick();
    b_wd = 1'b0;
    check("b_pend_ab", {15'd0, b_pend}, 16'h1);
    b_rl = 1'b1; b_raddr = 2'd0;
    tick();
    b_rl = 1'b0;
    check("b_swapped", {15'd0, b_swp}, 16'h1);
    tick();
    check("b_read_newest", b_rdata, 16'hBBBB);
    check("b_drop", {8'd0, b_drop}, DROP1);

    // nb3: writes with toggling read_latch but no write_done
    b_we = 1'b1; b_wdata = 16'hCCCC;
    for (int c = 0; c < 16; c++) begin
      b_rl = ((c / 4) % 2) == 1;
      tick();
      check("b_stable_read", b_rdata, 16'hBBBB);
      check("b_no_swap", {15'd0, b_swp}, 16'h0);
    end
    b_we = 1'b0; b_rl = 1'b0;

    // nb3: complete C, then D with simultaneous latch
    b_wd = 1'b1;
    tick();
    b_wd = 1'b1; b_rl = 1'b1; b_we = 1'b1; b_wdata = 16'hDDDD;
    tick();
    b_wd = 1'b0; b_rl = 1'b0; b_we = 1'b0;
    check("b_sim_pend", {15'd0, b_pend}, 16'h1);
    tick();
    check("b_sim_read", b_rdata, 16'hCCCC);
    b_rl = 1'b1;
    tick();
    b_rl = 1'b0;
    tick();
    last_b = b_rdata;
    check("b_latch_d", last_b, 16'hDDDD);
    check("b_sim_nodrop", {8'd0, b_drop}, DROP1);

    // Asynchronous reset mid-frame
    b_we = 1'b1; b_wdata = 16'h5555;
    tick();
    b_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_b", b_rdata, 16'h0);
    check("rst_mid_a", a_rdata, 16'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_raddr = 2'(i);
      tick();
      check("b_post_rst_read", b_rdata, 16'h0);
    end
    check("b_post_rst_pend", {15'd0, b_pend}, 16'h0);
    check("b_post_rst_drop", {8'd0, b_drop}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
